// File: rtl/dft_seq_ctrl_if.sv
// Control/handshake bundle between a DFT sequencer and its host/datapath.
// The master side requests transforms and feeds samples; the slave side is the sequencer.
interface dft_seq_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              skip_load;
    logic [ADDR_W-1:0] sample_num;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic              load_nCompute;
    logic [ADDR_W-1:0] n_idx;
    logic [ADDR_W-1:0] k_idx;
    logic              cache_we;
    logic              acc_clear;
    logic              acc_en;
    logic              res_we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, skip_load, sample_num, in_valid, abort,
        input  in_ready, load_nCompute, n_idx, k_idx,
        input  cache_we, acc_clear, acc_en, res_we, busy, done, err
    );

    modport slave (
        input  start, skip_load, sample_num, in_valid, abort,
        output in_ready, load_nCompute, n_idx, k_idx,
        output cache_we, acc_clear, acc_en, res_we, busy, done, err
    );
endinterface

// File: rtl/dft_seq_ctrl.sv
// Sequencer for a direct N-point DFT: loads samples into a cache, then for each bin
// clears the accumulator, runs N MACs, drains the MAC pipeline and stores one result.
module dft_seq_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int PIPE_LAT = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          ce,
    dft_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        COMPUTE,
        DRAIN,
        STORE,
        DONE
    } state_t;

    localparam logic [2:0]        DRAIN_LAST = (PIPE_LAT > 0) ? 3'(PIPE_LAT - 1) : 3'd0;
    localparam logic [ADDR_W-1:0] MIN_N      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_max_q, n_max_d;
    logic [ADDR_W-1:0] n_cnt_q, n_cnt_d;
    logic [ADDR_W-1:0] n_idx_q, n_idx_d;
    logic [ADDR_W-1:0] k_idx_q, k_idx_d;
    logic [2:0]        drain_q, drain_d;
    logic              in_ready_q, in_ready_d;
    logic              load_ncompute_q, load_ncompute_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cache_we_q, cache_we_d;
    logic              acc_clear_q, acc_clear_d;
    logic              acc_en_q, acc_en_d;
    logic              res_we_q, res_we_d;

    always_comb begin
        state_d    = state_q;
        n_max_d    = n_max_q;
        n_cnt_d    = n_cnt_q;
        k_idx_d    = k_idx_q;
        drain_d    = drain_q;
        err_d      = 1'b0;
        cache_we_d = 1'b0;

        if (ce) begin
            if (bus.abort && (state_q != IDLE)) begin
                state_d = IDLE;
                n_cnt_d = '0;
                k_idx_d = '0;
                err_d   = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        n_cnt_d = '0;
                        k_idx_d = '0;
                        if (bus.start && !bus.abort) begin
                            if (bus.sample_num < MIN_N) begin
                                err_d = 1'b1;
                            end else begin
                                n_max_d = bus.sample_num - ONE;
                                state_d = bus.skip_load ? CLEAR : LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (bus.in_valid && in_ready_q) begin
                            cache_we_d = 1'b1;
                            if (n_cnt_q == n_max_q) begin
                                n_cnt_d = '0;
                                state_d = CLEAR;
                            end else begin
                                n_cnt_d = n_cnt_q + ONE;
                            end
                        end
                    end
                    CLEAR: state_d = COMPUTE;
                    COMPUTE: begin
                        if (n_cnt_q == n_max_q) begin
                            drain_d = 3'd0;
                            state_d = (PIPE_LAT > 0) ? DRAIN : STORE;
                        end else begin
                            n_cnt_d = n_cnt_q + ONE;
                        end
                    end
                    DRAIN: begin
                        if (drain_q == DRAIN_LAST) begin
                            state_d = STORE;
                        end else begin
                            drain_d = drain_q + 3'd1;
                        end
                    end
                    STORE: begin
                        if (k_idx_q == n_max_q) begin
                            state_d = DONE;
                        end else begin
                            k_idx_d = k_idx_q + ONE;
                            n_cnt_d = '0;
                            state_d = CLEAR;
                        end
                    end
                    DONE: begin
                        state_d = IDLE;
                        n_cnt_d = '0;
                        k_idx_d = '0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Levels follow the state even while frozen; one-cycle strobes are dropped when ce is low.
        in_ready_d      = (state_d == LOAD);
        load_ncompute_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d          = (state_d != IDLE);
        acc_clear_d     = ce && (state_d == CLEAR);
        acc_en_d        = ce && (state_d == COMPUTE);
        res_we_d        = ce && (state_d == STORE);
        done_d          = ce && (state_d == DONE);

        // A cache write presents the address of the sample just accepted.
        if (!ce) begin
            n_idx_d = n_idx_q;
        end else if (cache_we_d) begin
            n_idx_d = n_cnt_q;
        end else begin
            n_idx_d = n_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= IDLE;
            n_max_q         <= '0;
            n_cnt_q         <= '0;
            n_idx_q         <= '0;
            k_idx_q         <= '0;
            drain_q         <= 3'd0;
            in_ready_q      <= 1'b0;
            load_ncompute_q <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            cache_we_q      <= 1'b0;
            acc_clear_q     <= 1'b0;
            acc_en_q        <= 1'b0;
            res_we_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_max_q         <= n_max_d;
            n_cnt_q         <= n_cnt_d;
            n_idx_q         <= n_idx_d;
            k_idx_q         <= k_idx_d;
            drain_q         <= drain_d;
            in_ready_q      <= in_ready_d;
            load_ncompute_q <= load_ncompute_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            cache_we_q      <= cache_we_d;
            acc_clear_q     <= acc_clear_d;
            acc_en_q        <= acc_en_d;
            res_we_q        <= res_we_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.load_nCompute = load_ncompute_q;
    assign bus.n_idx         = n_idx_q;
    assign bus.k_idx         = k_idx_q;
    assign bus.cache_we      = cache_we_q;
    assign bus.acc_clear     = acc_clear_q;
    assign bus.acc_en        = acc_en_q;
    assign bus.res_we        = res_we_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule
